uart_mmio_periph: RTL
=====================

Name: uart_mmio_periph

Overview:
- Memory-mapped 8N1 UART peripheral. It is the slave on the UART port of the SoC MMIO interconnect (the `mmio_if` slave side) and drives the board TX/RX pins.
- Contains an 8-deep TX FIFO, an 8-deep RX FIFO, a programmable baud divider, status/control registers and a level interrupt.
- Fixed single-cycle handshake: reads return data the cycle after acceptance; writes complete at acceptance.

Parameters:
- ADDR_W, 32, width of mmio_addr; only bits [4:2] are decoded.
- FIFO_DEPTH, 8, TX and RX FIFO depth; power of 2, at least 2.
- BAUD_DIV_RST, 434, reset value of BAUD_DIV (50 MHz / 115200).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- mmio_valid  in  1  access request.
- mmio_we  in  1  1 = write, 0 = read.
- mmio_addr  in  ADDR_W  byte address; register select = addr[4:2].
- mmio_wdata  in  32  write data.
- mmio_wstrb  in  4  byte enables.
- mmio_ready  out  1  tied to 1; accept = mmio_valid (every request is accepted the cycle it is presented).
- mmio_rdata  out  32  registered read data.
- uart_txd  out  1  serial out, idle high.
- uart_rxd  in  1  asynchronous serial in.
- irq  out  1  registered level interrupt.

Behaviour:
- Reset values: mmio_rdata=0, uart_txd=1, irq=0, FIFOs empty, sticky flags=0, BAUD_DIV=BAUD_DIV_RST, CTRL=0x3.
- Register map (addr[4:2]):
  - 0 TXDATA (W): push wdata[7:0] if wstrb[0]; if TX FIFO full, drop the byte and set tx_ovf. Reads return 0.
  - 1 RXDATA (R): {23'b0, valid, data[7:0]}. If RX FIFO non-empty: valid=1 and pop. If empty: returns 0, no pop. Writes ignored.
  - 2 STATUS: [0] tx_full, [1] tx_empty, [2] rx_nonempty, [3] rx_full, [4] tx_busy, [5] rx_overrun (sticky), [6] frame_err (sticky), [7] tx_ovf (sticky). Writing 1 with wstrb[0] clears sticky bits [7:5]; other bits read-only.
  - 3 BAUD_DIV: [15:0]; bit period = BAUD_DIV cycles. Written values below 4 are clamped to 4. Byte enables apply. A new value takes effect at the next bit-counter reload.
  - 4 CTRL: [0] tx_en, [1] rx_en, [2] rx_irq_en, [3] tx_irq_en. Byte enables apply.
  - 5-7: read 0, writes ignored.
- Read timing: on a read accept at cycle N, mmio_rdata is valid at N+1 and held until the next read accept. Writes do not change mmio_rdata. Read side effects (pop) occur at cycle N.
- TX FSM (IDLE → START → DATA → STOP → IDLE):
  - IDLE: when tx_en and FIFO non-empty, pop and latch the byte, go to START.
  - START: txd=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each.
  - STOP: txd=1 for BAUD_DIV cycles.
  - Back-to-back bytes: no extra idle cycle between STOP and the next START.
  - tx_busy = state≠IDLE.
  - Clearing tx_en mid-frame finishes the current frame, then stays in IDLE.
- RX FSM (IDLE → START → DATA → STOP):
  - Input passes through a 2-flop synchronizer.
  - IDLE: when rx_en, a synchronized falling edge enters START.
  - START: wait BAUD_DIV/2 cycles and resample. If the line is high it was a glitch: return to IDLE. Otherwise enter DATA.
  - DATA: sample 8 bits at BAUD_DIV intervals, LSB first.
  - STOP: sample the stop bit.
    - Stop=0: set frame_err, discard the byte.
    - Stop=1 and FIFO full: set rx_overrun, drop the byte.
    - Otherwise push the byte.
- Simultaneous events:
  - RX push and RXDATA pop in the same cycle: both occur, count unchanged. This also applies when full: the pop frees a slot, so there is no overrun.
  - TX FSM pop and TXDATA push in the same cycle when full: the push is accepted.
  - Sticky-clear write in the same cycle as a new sticky event: the set wins.
- FIFO pointers are log2(FIFO_DEPTH)-bit and wrap; an extra count register distinguishes full from empty.
- irq (registered): irq ← (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty).
- Reset mid-frame: next cycle uart_txd=1, both FSMs return to IDLE, FIFOs are emptied.

Test Plan:
- BAUD_DIV=4; write TXDATA=0xA5 → uart_txd: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. STATUS[4]=1 during the frame, then STATUS=0x02.
- Loop txd to rxd with BAUD_DIV=4; write 0x3C → after ~40 cycles STATUS[2]=1. Read RXDATA → 0x13C at N+1. A second read → 0x000.
- Write 9 bytes while tx_en=0 → STATUS[0]=1 and STATUS[7]=1. Write STATUS=0x80 → bit7 clears. Set tx_en → exactly 8 frames are sent.
- Drive 9 frames into rxd without reading → STATUS[5]=1 and 8 bytes are readable in order. Drive a frame with stop=0 → STATUS[6]=1 and no push.
- Pulse rxd low for 1 cycle with BAUD_DIV=8 → no byte received and no flags set.
- Set CTRL=0x7 and receive one byte → irq=1 one cycle after the push. Read RXDATA → irq=0 within 2 cycles. Assert rst mid-TX-frame → uart_txd=1 on the next cycle.

Source files
------------

// File: rtl/mmio_if.sv
// mmio_if: single-cycle MMIO request/response bus between interconnect and peripheral
interface mmio_if #(parameter int ADDR_W = 32) ();
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              ready;
  logic [31:0]       rdata;
  modport master (output valid, we, addr, wdata, wstrb, input ready, rdata);
  modport slave (input valid, we, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/uart_mmio_periph.sv
// uart_mmio_periph: memory-mapped 8N1 UART with TX/RX FIFOs, baud divider and level irq
module uart_mmio_periph #(
  parameter int ADDR_W       = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int BAUD_DIV_RST = 434
) (
  input  logic   clk,
  input  logic   rst,
  mmio_if.slave  bus,
  output logic   uart_txd,
  input  logic   uart_rxd,
  output logic   irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [2:0] sel;
  logic wr, rd, clr;
  logic [15:0] baud, baud_new;
  logic [3:0] ctrl;
  logic rx_ovr, frm_err, tx_ovf;
  logic [31:0] rdata_q, rd_mux;
  logic [7:0] status;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_cnt, rx_cnt;
  logic tx_full, tx_empty, rx_full, rx_ne;
  logic tx_req, tx_push, tx_pop, rx_push, rx_pop, rx_done, rx_bad;
  state_t tx_st, tx_st_n, rx_st, rx_st_n;
  logic [15:0] tx_tmr, tx_tmr_n, rx_tmr, rx_tmr_n;
  logic [2:0] tx_idx, tx_idx_n, rx_idx, rx_idx_n;
  logic [7:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
  logic rx_s1, rx_s2, rx_prev;
  logic unused_bits;
  assign unused_bits = ^{bus.addr[ADDR_W-1:5], bus.addr[1:0], bus.wdata[31:16], bus.wstrb[3:2]};
  assign sel = bus.addr[4:2];
  assign wr = bus.valid & bus.we;
  assign rd = bus.valid & ~bus.we;
  assign clr = wr & (sel == 3'd2) & bus.wstrb[0];
  assign bus.ready = 1'b1;
  assign bus.rdata = rdata_q;
  assign tx_full = tx_cnt == FULL;
  assign tx_empty = tx_cnt == '0;
  assign rx_full = rx_cnt == FULL;
  assign rx_ne = rx_cnt != '0;
  assign tx_req = wr & (sel == 3'd0) & bus.wstrb[0];
  assign tx_push = tx_req & (~tx_full | tx_pop);
  assign rx_pop = rd & (sel == 3'd1) & rx_ne;
  assign rx_push = rx_done & (~rx_full | rx_pop);
  assign baud_new = {bus.wstrb[1] ? bus.wdata[15:8] : baud[15:8], bus.wstrb[0] ? bus.wdata[7:0] : baud[7:0]};
  assign status = {tx_ovf, frm_err, rx_ovr, tx_st != IDLE, rx_full, rx_ne, tx_empty, tx_full};
  assign rd_mux = sel == 3'd1 ? (rx_ne ? {23'b0, 1'b1, rx_mem[rx_rp]} : 32'b0) :
                  sel == 3'd2 ? {24'b0, status} :
                  sel == 3'd3 ? {16'b0, baud} :
                  sel == 3'd4 ? {28'b0, ctrl} : 32'b0;
  assign uart_txd = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
  // FIFO storage; occupancy is tracked by pointers and counts, so no reset needed
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end
  // Registers, FIFO pointers, sticky flags, read data, rxd synchronizer and irq
  always_ff @(posedge clk) begin
    if (rst) begin
      baud <= 16'(BAUD_DIV_RST);
      ctrl <= 4'h3;
      {rx_ovr, frm_err, tx_ovf} <= '0;
      rdata_q <= '0;
      {tx_wp, tx_rp, rx_wp, rx_rp} <= '0;
      {tx_cnt, rx_cnt} <= '0;
      {rx_s1, rx_s2, rx_prev} <= 3'b111;
      irq <= 1'b0;
    end else begin
      if (wr & (sel == 3'd3) & |bus.wstrb[1:0]) baud <= baud_new < 16'd4 ? 16'd4 : baud_new;
      if (wr & (sel == 3'd4) & bus.wstrb[0]) ctrl <= bus.wdata[3:0];
      rx_ovr <= (rx_done & rx_full & ~rx_pop) | (rx_ovr & ~(clr & bus.wdata[5]));
      frm_err <= rx_bad | (frm_err & ~(clr & bus.wdata[6]));
      tx_ovf <= (tx_req & ~tx_push) | (tx_ovf & ~(clr & bus.wdata[7]));
      if (rd) rdata_q <= rd_mux;
      tx_wp <= tx_wp + AW'(tx_push);
      tx_rp <= tx_rp + AW'(tx_pop);
      rx_wp <= rx_wp + AW'(rx_push);
      rx_rp <= rx_rp + AW'(rx_pop);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      {rx_prev, rx_s2, rx_s1} <= {rx_s2, rx_s1, uart_rxd};
      irq <= (ctrl[2] & rx_ne) | (ctrl[3] & tx_empty);
    end
  end
  // TX FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= IDLE;
      tx_tmr <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
    end else begin
      tx_st <= tx_st_n;
      tx_tmr <= tx_tmr_n;
      tx_idx <= tx_idx_n;
      tx_sh <= tx_sh_n;
    end
  end
  // TX next state: the bit timer counts down from BAUD_DIV-1; STOP chains straight into START
  always_comb begin
    tx_st_n = tx_st;
    tx_tmr_n = tx_tmr - 16'd1;
    tx_idx_n = tx_idx;
    tx_sh_n = tx_sh;
    tx_pop = 1'b0;
    case (tx_st)
      IDLE: begin
        tx_tmr_n = baud - 16'd1;
        if (ctrl[0] & ~tx_empty) begin
          tx_pop = 1'b1;
          tx_sh_n = tx_mem[tx_rp];
          tx_st_n = START;
        end
      end
      START: if (tx_tmr == '0) begin
        tx_tmr_n = baud - 16'd1;
        tx_idx_n = '0;
        tx_st_n = DATA;
      end
      DATA: if (tx_tmr == '0) begin
        tx_tmr_n = baud - 16'd1;
        tx_sh_n = tx_sh >> 1;
        tx_idx_n = tx_idx + 3'd1;
        tx_st_n = tx_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tx_tmr == '0) begin
        tx_tmr_n = baud - 16'd1;
        tx_pop = ctrl[0] & ~tx_empty;
        tx_sh_n = tx_pop ? tx_mem[tx_rp] : tx_sh;
        tx_st_n = tx_pop ? START : IDLE;
      end
    endcase
  end
  // RX FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= IDLE;
      rx_tmr <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
    end else begin
      rx_st <= rx_st_n;
      rx_tmr <= rx_tmr_n;
      rx_idx <= rx_idx_n;
      rx_sh <= rx_sh_n;
    end
  end
  // RX next state: half-bit wait from the falling edge puts every later sample mid-bit
  always_comb begin
    rx_st_n = rx_st;
    rx_tmr_n = rx_tmr - 16'd1;
    rx_idx_n = rx_idx;
    rx_sh_n = rx_sh;
    rx_done = 1'b0;
    rx_bad = 1'b0;
    case (rx_st)
      IDLE: begin
        rx_tmr_n = (baud >> 1) - 16'd1;
        if (ctrl[1] & rx_prev & ~rx_s2) rx_st_n = START;
      end
      START: if (rx_tmr == '0) begin
        rx_tmr_n = baud - 16'd1;
        rx_idx_n = '0;
        rx_st_n = rx_s2 ? IDLE : DATA;
      end
      DATA: if (rx_tmr == '0) begin
        rx_tmr_n = baud - 16'd1;
        rx_sh_n = {rx_s2, rx_sh[7:1]};
        rx_idx_n = rx_idx + 3'd1;
        rx_st_n = rx_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (rx_tmr == '0) begin
        rx_done = rx_s2;
        rx_bad = ~rx_s2;
        rx_st_n = IDLE;
      end
    endcase
  end
endmodule
